// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: Hack control-word bit positions, named operations and FSM states for alu_seq.
package alu_seq_pkg;
  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;
  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_ONE  = 6'b111111;
  localparam logic [5:0] OP_X    = 6'b001100;
  localparam logic [5:0] OP_Y    = 6'b110000;
  localparam logic [5:0] OP_NEGX = 6'b001111;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_XMY  = 6'b010011;
  localparam logic [5:0] OP_YMX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010101;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_seq_core.sv
// hack_alu_core: combinational Hack ALU at any WIDTH (x, y, ctrl -> result, zr, ng).
module hack_alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] xz, yz, xa, ya, fo;
  always_comb begin
    xz = ctrl[CTRL_ZX] ? '0 : x;
    xa = ctrl[CTRL_NX] ? ~xz : xz;
    yz = ctrl[CTRL_ZY] ? '0 : y;
    ya = ctrl[CTRL_NY] ? ~yz : yz;
    fo = ctrl[CTRL_F] ? xa + ya : xa & ya;
    result = ctrl[CTRL_NO] ? ~fo : fo;
    zr = result == '0;
    ng = result[WIDTH-1];
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready Hack ALU; the shift-add multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] out_q, out_d, core_x, core_res;
  logic [5:0] core_ctrl;
  logic out_valid_q, out_valid_d, zr_q, zr_d, ng_q, ng_d, core_zr, core_ng;
  logic free, accept, is_mul, mul_done, load;
  assign free = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, step_sum;
  assign is_mul = mul;
  assign in_ready = state_q == S_IDLE && free;
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  // During MUL the core passes the product through (OP_X) so zr/ng come from one place
  assign core_x = state_q == S_MUL ? step_sum : x;
  assign core_ctrl = state_q == S_MUL ? OP_X : ctrl;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    mul_done = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept && is_mul) begin
        state_d = S_MUL;
        cnt_d = '0;
        mcand_d = x;
        mplier_d = y;
        acc_d = '0;
      end
    end else if (cnt_q != LAST) begin
      acc_d = step_sum;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end else if (free) begin
      mul_done = 1'b1;
      state_d = S_IDLE;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
    end
  end
`else
  // Without the multiplier, mul is treated as 0 and every command is a 1-cycle ALU op
  assign is_mul = mul & 1'b0;
  assign mul_done = 1'b0;
  assign in_ready = free;
  assign core_x = x;
  assign core_ctrl = ctrl;
`endif
  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x(core_x),
    .y(y),
    .ctrl(core_ctrl),
    .result(core_res),
    .zr(core_zr),
    .ng(core_ng)
  );
  always_comb begin
    load = mul_done || (accept && !is_mul);
    out_valid_d = load || (out_valid_q && !out_ready);
    out_d = load ? core_res : out_q;
    zr_d = load ? core_zr : zr_q;
    ng_d = load ? core_ng : ng_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      zr_q <= zr_d;
      ng_q <= ng_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out = out_q;
  assign zr = zr_q;
  assign ng = ng_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, directed handshake/reset sequences and a random scoreboard for alu_seq (honours ALU_SEQ_MUL_EN).
module tb_alu_seq;
  import alu_seq_pkg::*;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, mul = 1'b0, out_valid, out_ready = 1'b1, zr, ng;
  logic [15:0] x = '0, y = '0, out;
  logic [5:0] ctrl = OP_ADD;
  logic in_valid8 = 1'b0, in_ready8, mul8 = 1'b0, out_valid8, zr8, ng8;
  logic [7:0] x8 = '0, y8 = '0, out8;
  logic [5:0] ctrl8 = OP_ADD;
  int n_checks = 0, n_fail = 0;
  logic [15:0] q[$];
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] e;
    logic        z;
    logic        n;
  } vec_t;
  vec_t vt[8];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .ctrl(ctrl), .mul(mul), .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr), .ng(ng)
  );
  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8),
    .ctrl(ctrl8), .mul(mul8), .out_valid(out_valid8), .out_ready(1'b1), .out(out8), .zr(zr8), .ng(ng8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the Hack rules applied to unsigned integers; inversion is 2^16-1 minus the value
  function automatic logic [15:0] ref_cmd(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c, input logic m);
    longint unsigned xv, yv, r;
    if (MUL_ON && m) return 16'((longint'(a) * longint'(b)) % 65536);
    xv = c[5] ? 0 : longint'(a);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : longint'(b);
    if (c[2]) yv = 65535 - yv;
    r = c[1] ? (xv + yv) % 65536 : (xv & yv);
    if (c[0]) r = 65535 - r;
    return 16'(r);
  endfunction

  task automatic wait_valid(output int k, output int busy);
    busy = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      if (!in_ready) busy++;
    end
  endtask

  task automatic rnd_cycle(input bit gen);
    @(negedge clk);
    if (out_valid) begin
      check("valid_has_entry", 32'(q.size() != 0), 1);
      if (q.size() != 0) check("hold_out", out, q[0]);
    end
    if (gen) begin
      in_valid = 1'($urandom);
      x = 16'($urandom);
      y = 16'($urandom);
      ctrl = 6'($urandom);
      mul = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 3) != 0;
    end else begin
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    #1;
`ifndef ALU_SEQ_MUL_EN
    check("in_ready_rule", in_ready, !out_valid || out_ready);
`endif
    if (out_valid && out_ready && q.size() != 0) begin
      check("rnd_zr", zr, q[0] == 16'd0);
      check("rnd_ng", ng, q[0][15]);
      void'(q.pop_front());
    end
    if (in_valid && in_ready) q.push_back(ref_cmd(x, y, ctrl, mul));
  endtask

  initial begin
    int k, busy;
    vt[0] = '{16'd16, 16'd15, OP_ADD,  16'd31,     1'b0, 1'b0};
    vt[1] = '{16'd16, 16'd15, OP_XMY,  16'd1,      1'b0, 1'b0};
    vt[2] = '{16'd16, 16'd15, OP_YMX,  16'hFFFF,   1'b0, 1'b1};
    vt[3] = '{16'd16, 16'd15, OP_ZERO, 16'd0,      1'b1, 1'b0};
    vt[4] = '{16'd3,  16'd9,  OP_ONE,  16'd1,      1'b0, 1'b0};
    vt[5] = '{16'd12, 16'd10, OP_AND,  16'd8,      1'b0, 1'b0};
    vt[6] = '{16'd12, 16'd10, OP_OR,   16'd14,     1'b0, 1'b0};
    vt[7] = '{16'd16, 16'd0,  OP_NEGX, 16'hFFF0,   1'b0, 1'b1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_zr", zr, 0);
    check("rst_ng", ng, 0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);

    // Back-to-back ALU stream: each result appears one cycle after its accept
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("vec_valid", out_valid, 1);
        check("vec_out", out, vt[i-1].e);
        check("vec_zr", zr, vt[i-1].z);
        check("vec_ng", ng, vt[i-1].n);
      end
      if (i < 8) begin
        in_valid = 1'b1; x = vt[i].x; y = vt[i].y; ctrl = vt[i].c; mul = 1'b0;
        #1 check("vec_in_ready", in_ready, 1);
      end else in_valid = 1'b0;
      @(negedge clk);
    end

    // Multiply 300*250 (ALU add when the multiplier is not built)
    in_valid = 1'b1; x = 16'd300; y = 16'd250; ctrl = OP_ADD; mul = 1'b1;
    #1 check("mul_in_ready", in_ready, 1);
    wait_valid(k, busy);
    mul = 1'b0;
    check("mul_latency", k, MUL_ON ? 17 : 1);
    check("mul_busy", busy, MUL_ON ? 16 : 0);
    check("mul_out", out, MUL_ON ? 9464 : 550);
    check("mul_zr", zr, 0);
    check("mul_ng", ng, 0);
    @(negedge clk);
    check("mul_drained", out_valid, 0);

    // Backpressure: OP_ONE held while an OP_AND waits, then drain+accept in one cycle
    out_ready = 1'b0; in_valid = 1'b1; x = 16'd5; y = 16'd6; ctrl = OP_ONE;
    @(negedge clk);
    in_valid = 1'b1; x = 16'd12; y = 16'd10; ctrl = OP_AND;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_out", out, 1);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_out", out, 8);
    @(negedge clk);
    check("bp_empty", out_valid, 0);

    // Reset in the middle of a 7*9 multiply
    in_valid = 1'b1; x = 16'd7; y = 16'd9; ctrl = OP_ADD; mul = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mul = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_out", out, 0);
    check("mrst_in_ready", in_ready, 1);
    in_valid = 1'b1; x = 16'd1; y = 16'd2; ctrl = OP_ADD;
    @(negedge clk);
    in_valid = 1'b0;
    check("mrst_add_valid", out_valid, 1);
    check("mrst_add_out", out, 3);
    repeat (20) begin
      @(negedge clk);
      check("mrst_no_stray", out_valid, 0);
    end

    // WIDTH=8 instance: 0xFF*0x02 (ALU add 0xFF+0x02 without the multiplier)
    in_valid8 = 1'b1; x8 = 8'hFF; y8 = 8'h02; ctrl8 = OP_ADD; mul8 = 1'b1;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      if (out_valid8) break;
    end
    check("w8_latency", k, MUL_ON ? 9 : 1);
    check("w8_out", out8, MUL_ON ? 8'hFE : 8'h01);
    check("w8_ng", ng8, MUL_ON ? 1 : 0);
    check("w8_zr", zr8, 0);

    // Random traffic against the scoreboard, then drain
    for (int c = 0; c < 1500; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 100 && (q.size() != 0 || out_valid); c++) rnd_cycle(1'b0);
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
